// File: rtl/count_checker.sv
// Observer for a loadable up-counter: predicts each next count from the observed
// bus, locks after consecutive correct predictions, then flags and counts deviations.
module count_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned LOCK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [WIDTH-1:0]     q,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sat,
  output logic [WIDTH-1:0]     last_bad
);

  localparam int unsigned     MC_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     exp_r, exp_nxt;
  logic                 exp_valid, exp_valid_nxt;
  logic [MC_W-1:0]      match_cnt, match_cnt_nxt;
  logic                 bad;
  logic                 pred_ok;
  logic [ERR_CNT_W-1:0] err_base, err_count_nxt;
  logic                 err_sat_nxt;
  logic [WIDTH-1:0]     last_bad_nxt;

  always_comb begin
    state_nxt     = state;
    exp_nxt       = exp_r;
    exp_valid_nxt = exp_valid;
    match_cnt_nxt = match_cnt;
    bad           = 1'b0;
    pred_ok       = (q == exp_r);

    // clear_err is applied before a same-cycle mismatch is counted
    err_base      = clear_err ? '0 : err_count;
    err_sat_nxt   = clear_err ? 1'b0 : err_sat;
    last_bad_nxt  = clear_err ? '0 : last_bad;
    err_count_nxt = err_base;

    if (!en) begin
      state_nxt     = IDLE;
      exp_valid_nxt = 1'b0;
      match_cnt_nxt = '0;
    end else begin
      exp_nxt       = load ? load_value : q + 1'b1;
      exp_valid_nxt = 1'b1;
      unique case (state)
        IDLE: begin
          state_nxt     = ACQUIRE;
          match_cnt_nxt = '0;
        end
        ACQUIRE: begin
          if (exp_valid) begin
            if (pred_ok) begin
              if (match_cnt + 1'b1 == LOCK_TGT) begin
                state_nxt     = TRACK;
                match_cnt_nxt = '0;
              end else begin
                match_cnt_nxt = match_cnt + 1'b1;
              end
            end else begin
              match_cnt_nxt = '0;
            end
          end
        end
        TRACK: begin
          if (exp_valid && !pred_ok) bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (bad) begin
      last_bad_nxt = q;
      if (err_base != '1) err_count_nxt = err_base + 1'b1;
      if (err_count_nxt == '1) err_sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      exp_r     <= '0;
      exp_valid <= 1'b0;
      match_cnt <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
      err_sat   <= 1'b0;
      last_bad  <= '0;
    end else begin
      state     <= state_nxt;
      exp_r     <= exp_nxt;
      exp_valid <= exp_valid_nxt;
      match_cnt <= match_cnt_nxt;
      locked    <= (state_nxt == TRACK);
      mismatch  <= bad;
      err_count <= err_count_nxt;
      err_sat   <= err_sat_nxt;
      last_bad  <= last_bad_nxt;
    end
  end

endmodule
